controle_op: RTL and testbench
==============================

CONTROLE_OP -- requirements
Module: controle_op

Interface
REQ-001 Parameter CLEAR, 2'd0, register op code: clear.
REQ-002 Parameter LOAD, 2'd1, register op code: load.
REQ-003 Parameter HOLD, 2'd2, register op code: hold.
REQ-004 Parameter SHIFTL, 2'd3, register op code: shift left by 1.
REQ-005 Parameter ULA_ADD / ULA_SUB / ULA_PASS, 2'd0 / 2'd1 / 2'd2, ULA select: Y+X, Y-X, pass bus input to Y.
REQ-006 Clocking: one clock; reset is synchronous and active-high.
REQ-007 clock  input  1  sole clock, all state updates on rising edge.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 start  input  1  request; sampled only in IDLE.
REQ-010 opcode  input  2  operation: 0 ADD, 1 SUB, 2 MUL (repeated add), 3 SHL.
REQ-011 n  input  4  iteration count for MUL/SHL; ignored for ADD/SUB.
REQ-012 tx, ty, tz  output  2 each  op codes to registers X, Y, Z.
REQ-013 tula  output  2  ULA select.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 estado  output  3  current state encoding, for debug.

Function
REQ-017 States and encodings: IDLE=0, LDX=1, LDY=2, EXEC=3, SHIFT=4, STORE=5, DONE=6; code 7 SHALL go to IDLE on the next edge.
REQ-018 Outputs SHALL be Moore-decoded from the state register and latched op only; no combinational path from start/opcode/n to any output.
REQ-019 IDLE: tx=ty=tz=HOLD, tula=ULA_ADD, busy=0, done=0.
REQ-020 IDLE with start=1: latch opcode into op, n into cnt, go LDX; start=0: stay.
REQ-021 LDX: tx=LOAD, ty=CLEAR, tz=HOLD, tula=ULA_PASS; next LDY.
REQ-022 LDY: tx=HOLD, tz=HOLD, tula=ULA_PASS; ty=CLEAR if op=MUL, else ty=LOAD.
REQ-023 LDY next: ADD/SUB -> EXEC; MUL -> EXEC if cnt!=0 else STORE; SHL -> SHIFT if cnt!=0 else STORE.
REQ-024 EXEC: tx=HOLD, ty=LOAD, tz=HOLD; tula=ULA_SUB if op=SUB, else ULA_ADD.
REQ-025 EXEC next: ADD/SUB -> STORE; MUL: cnt<=cnt-1, -> STORE when cnt==1, else stay EXEC.
REQ-026 SHIFT: tx=HOLD, ty=SHIFTL, tz=HOLD, tula=ULA_PASS; cnt<=cnt-1, -> STORE when cnt==1, else stay.
REQ-027 STORE: tx=HOLD, ty=HOLD, tz=LOAD, tula=ULA_PASS; next DONE.
REQ-028 DONE: all HOLD, tula=ULA_PASS, done=1, busy=1; next IDLE.
REQ-029 cnt SHALL be 4-bit, decremented only in EXEC (op=MUL) and SHIFT, never wraps below 0.
REQ-030 Latency, start sampled at edge 0: ADD/SUB done at cycle 5; MUL/SHL done at cycle 4+n (n=0 -> 4, n=15 -> 19).
REQ-031 start while busy (including DONE) SHALL be ignored; opcode/n changes while busy SHALL not affect the running operation.
REQ-032 Back-to-back: start held high SHALL begin a new operation on the edge after returning to IDLE (one IDLE cycle minimum).

Reset
REQ-033 reset=1 at an edge: state<=IDLE, op<=0, cnt<=0; hence tx=ty=tz=HOLD, tula=ULA_ADD, busy=0, done=0, estado=0.
REQ-034 reset SHALL have priority over start and over any in-progress operation; aborted operation produces no done pulse and no tz=LOAD thereafter.

Verification
REQ-035 Reset then start, opcode=0: estado 1,2,3,5,6,0; EXEC shows ty=LOAD tula=0; tz=LOAD only in STORE; done high exactly at cycle 5.
REQ-036 opcode=2, n=3: LDY ty=CLEAR; EXEC for 3 cycles ty=LOAD tula=0; STORE; done at cycle 7.
REQ-037 opcode=3, n=0: LDX, LDY, STORE, DONE, no SHIFT cycle; done at cycle 4; opcode=3, n=2: two ty=SHIFTL cycles, done at cycle 6.
REQ-038 opcode=1 started, start pulsed and opcode/n changed during EXEC: tula=1 in EXEC, exactly one done, no restart until IDLE.
REQ-039 opcode=2, n=15, reset asserted during the 4th EXEC cycle: next edge estado=0, all outputs HOLD, busy=0, no done for 20 cycles.
REQ-040 start held high continuously with opcode=0: done pulses every 6 cycles, each separated by one IDLE cycle.

Source files
------------

// File: rtl/controle_op_if.sv
// Control bundle between the sequencer and its datapath: request inputs and
// Moore-decoded register/ULA commands.
interface controle_op_if;
  logic       start;
  logic [1:0] opcode;
  logic [3:0] n;
  logic [1:0] tx;
  logic [1:0] ty;
  logic [1:0] tz;
  logic [1:0] tula;
  logic       busy;
  logic       done;
  logic [2:0] estado;

  modport master (
    output start, opcode, n,
    input  tx, ty, tz, tula, busy, done, estado
  );

  modport slave (
    input  start, opcode, n,
    output tx, ty, tz, tula, busy, done, estado
  );
endinterface

// File: rtl/controle_op.sv
// Sequencer for an X/Y/Z register datapath with a small ULA: ADD/SUB take 5 cycles
// from the start edge to done, MUL/SHL take 4+n; start is ignored while busy.
module controle_op (
  input  logic          clock,
  input  logic          reset,
  controle_op_if.slave  bus
);

  localparam logic [1:0] CLEAR  = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] SHIFTL = 2'd3;

  localparam logic [1:0] ULA_ADD  = 2'd0;
  localparam logic [1:0] ULA_SUB  = 2'd1;
  localparam logic [1:0] ULA_PASS = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_SHL = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDX   = 3'd1,
    LDY   = 3'd2,
    EXEC  = 3'd3,
    SHIFT = 3'd4,
    STORE = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic [1:0] tx;
    logic [1:0] ty;
    logic [1:0] tz;
    logic [1:0] tula;
    logic       busy;
    logic       done;
  } ctrl_t;

  state_t     state;
  logic [1:0] op;
  logic [3:0] cnt;
  ctrl_t      ctrl;

  // Command decode for a state; outputs are registered from the state being
  // entered, so they always match the state register with no start->output path.
  function automatic ctrl_t decode(input state_t s, input logic [1:0] o);
    ctrl_t c;
    c.tx   = HOLD;
    c.ty   = HOLD;
    c.tz   = HOLD;
    c.tula = ULA_PASS;
    c.busy = 1'b1;
    c.done = 1'b0;
    case (s)
      IDLE: begin
        c.tula = ULA_ADD;
        c.busy = 1'b0;
      end
      LDX: begin
        c.tx = LOAD;
        c.ty = CLEAR;
      end
      LDY: begin
        c.ty = (o == OP_MUL) ? CLEAR : LOAD;
      end
      EXEC: begin
        c.ty   = LOAD;
        c.tula = (o == OP_SUB) ? ULA_SUB : ULA_ADD;
      end
      SHIFT: begin
        c.ty = SHIFTL;
      end
      STORE: begin
        c.tz = LOAD;
      end
      DONE: begin
        c.done = 1'b1;
      end
      default: begin
        c.tula = ULA_ADD;
        c.busy = 1'b0;
      end
    endcase
    return c;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      op    <= OP_ADD;
      cnt   <= 4'd0;
      ctrl  <= decode(IDLE, OP_ADD);
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op    <= bus.opcode;
            cnt   <= bus.n;
            state <= LDX;
            ctrl  <= decode(LDX, bus.opcode);
          end else begin
            ctrl  <= decode(IDLE, op);
          end
        end

        LDX: begin
          state <= LDY;
          ctrl  <= decode(LDY, op);
        end

        LDY: begin
          if (op == OP_ADD || op == OP_SUB) begin
            state <= EXEC;
            ctrl  <= decode(EXEC, op);
          end else if (cnt == 4'd0) begin
            state <= STORE;
            ctrl  <= decode(STORE, op);
          end else if (op == OP_SHL) begin
            state <= SHIFT;
            ctrl  <= decode(SHIFT, op);
          end else begin
            state <= EXEC;
            ctrl  <= decode(EXEC, op);
          end
        end

        // MUL iterates here once per count; ADD/SUB pass through in one cycle.
        EXEC: begin
          if (op == OP_MUL && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
          if (op == OP_MUL && cnt > 4'd1) begin
            state <= EXEC;
            ctrl  <= decode(EXEC, op);
          end else begin
            state <= STORE;
            ctrl  <= decode(STORE, op);
          end
        end

        SHIFT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
          if (cnt > 4'd1) begin
            state <= SHIFT;
            ctrl  <= decode(SHIFT, op);
          end else begin
            state <= STORE;
            ctrl  <= decode(STORE, op);
          end
        end

        STORE: begin
          state <= DONE;
          ctrl  <= decode(DONE, op);
        end

        DONE: begin
          state <= IDLE;
          ctrl  <= decode(IDLE, op);
        end

        default: begin
          state <= IDLE;
          ctrl  <= decode(IDLE, op);
        end
      endcase
    end
  end

  assign bus.tx     = ctrl.tx;
  assign bus.ty     = ctrl.ty;
  assign bus.tz     = ctrl.tz;
  assign bus.tula   = ctrl.tula;
  assign bus.busy   = ctrl.busy;
  assign bus.done   = ctrl.done;
  assign bus.estado = state;

endmodule

// File: tb/tb_controle_op.sv
// Scoreboard bench for controle_op: each operation pushes its expected per-cycle
// command trace, and every cycle pops one entry and compares it against the outputs.
module tb_controle_op;

  localparam logic [1:0] CLEAR = 2'd0, LOAD = 2'd1, HOLD = 2'd2, SHIFTL = 2'd3;
  localparam logic [1:0] U_ADD = 2'd0, U_SUB = 2'd1, U_PASS = 2'd2;
  localparam logic [2:0] S_IDLE = 3'd0, S_LDX = 3'd1, S_LDY = 3'd2, S_EXEC = 3'd3,
                         S_SHIFT = 3'd4, S_STORE = 3'd5, S_DONE = 3'd6;

  // {estado, tx, ty, tz, tula, busy, done}
  typedef logic [12:0] obs_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  obs_t expq[$];

  always #5 clock = ~clock;

  controle_op_if bus();

  controle_op dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic obs_t expect_of(input logic [2:0] st, input logic [1:0] op);
    case (st)
      S_IDLE:  return {st, HOLD, HOLD,   HOLD, U_ADD,  1'b0, 1'b0};
      S_LDX:   return {st, LOAD, CLEAR,  HOLD, U_PASS, 1'b1, 1'b0};
      S_LDY:   return {st, HOLD, (op == 2'd2) ? CLEAR : LOAD, HOLD, U_PASS, 1'b1, 1'b0};
      S_EXEC:  return {st, HOLD, LOAD,   HOLD, (op == 2'd1) ? U_SUB : U_ADD, 1'b1, 1'b0};
      S_SHIFT: return {st, HOLD, SHIFTL, HOLD, U_PASS, 1'b1, 1'b0};
      S_STORE: return {st, HOLD, HOLD,   LOAD, U_PASS, 1'b1, 1'b0};
      default: return {S_DONE, HOLD, HOLD, HOLD, U_PASS, 1'b1, 1'b1};
    endcase
  endfunction

  function automatic obs_t observed();
    return {bus.estado, bus.tx, bus.ty, bus.tz, bus.tula, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d tx=%0d ty=%0d tz=%0d tula=%0d busy=%0b done=%0b, expected st=%0d tx=%0d ty=%0d tz=%0d tula=%0d busy=%0b done=%0b",
               tag, got[12:10], got[9:8], got[7:6], got[5:4], got[3:2], got[1], got[0],
               exp[12:10], exp[9:8], exp[7:6], exp[5:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // One operation: LDX, LDY, body, STORE, DONE, then the IDLE cycle that follows.
  task automatic push_trace(input logic [1:0] op, input logic [3:0] cnt);
    expq.push_back(expect_of(S_LDX, op));
    expq.push_back(expect_of(S_LDY, op));
    if (op < 2'd2) begin
      expq.push_back(expect_of(S_EXEC, op));
    end else begin
      for (int i = 0; i < int'(cnt); i++)
        expq.push_back(expect_of((op == 2'd2) ? S_EXEC : S_SHIFT, op));
    end
    expq.push_back(expect_of(S_STORE, op));
    expq.push_back(expect_of(S_DONE, op));
    expq.push_back(expect_of(S_IDLE, op));
  endtask

  // Runs reps operations (start held high when hold=1), plus one trailing IDLE.
  // At cycles d1/d2 start is pulsed and opcode/n scrambled to probe busy-time isolation.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] cnt,
                        input bit hold, input int reps, input int d1, input int d2);
    int k;
    k = 0;
    bus.opcode = op;
    bus.n      = cnt;
    bus.start  = 1'b1;
    for (int r = 0; r < reps; r++) push_trace(op, cnt);
    expq.push_back(expect_of(S_IDLE, op));
    while (expq.size() > 0 && k < 200) begin
      @(posedge clock);
      #1;
      k++;
      check($sformatf("%s c%0d", tag, k), observed(), expq.pop_front());
      bus.start = hold && (expq.size() > 1);
      if (k == d1 || k == d2) begin
        bus.start  = 1'b1;
        bus.opcode = ~op;
        bus.n      = 4'd9;
      end
    end
    if (expq.size() != 0) begin
      check({tag, " timeout"}, obs_t'(expq.size()), '0);
      expq.delete();
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.opcode = 2'd2;
    bus.n      = 4'd5;
    repeat (2) @(posedge clock);
    #1;
    check("reset with start", observed(), expect_of(S_IDLE, 2'd0));
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    check("reset idle", observed(), expect_of(S_IDLE, 2'd0));
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle no start", observed(), expect_of(S_IDLE, 2'd0));

    run_op("add",      2'd0, 4'd7,  1'b0, 1, 0, 0);
    run_op("mul3",     2'd2, 4'd3,  1'b0, 1, 0, 0);
    run_op("mul0",     2'd2, 4'd0,  1'b0, 1, 0, 0);
    run_op("shl0",     2'd3, 4'd0,  1'b0, 1, 0, 0);
    run_op("shl2",     2'd3, 4'd2,  1'b0, 1, 0, 0);
    run_op("shl15",    2'd3, 4'd15, 1'b0, 1, 0, 0);
    run_op("sub_dist", 2'd1, 4'd4,  1'b0, 1, 3, 5);
    run_op("mul1_dist",2'd2, 4'd1,  1'b0, 1, 1, 2);
    run_op("b2b_add",  2'd0, 4'd0,  1'b1, 3, 0, 0);

    // Abort a long MUL in its 4th EXEC cycle; reset must win over a held start.
    bus.opcode = 2'd2;
    bus.n      = 4'd15;
    bus.start  = 1'b1;
    push_trace(2'd2, 4'd15);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("abort c%0d", k), observed(), expq.pop_front());
      bus.start = 1'b0;
    end
    expq.delete();
    reset     = 1'b1;
    bus.start = 1'b1;
    for (int i = 0; i < 20; i++) expq.push_back(expect_of(S_IDLE, 2'd0));
    for (int k = 1; k <= 20 && expq.size() > 0; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("abort idle c%0d", k), observed(), expq.pop_front());
      reset     = 1'b0;
      bus.start = 1'b0;
    end

    run_op("after_abort", 2'd1, 4'd0, 1'b0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
